axil_req_arbiter: RTL



---
 rtl/axil_req_arbiter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_req_arbiter.sv
// axil_req_arbiter
//
// Round-robin scheduler that funnels up to NUM_REQ simple register-style
// requesters onto one AXI-Lite master port. One transaction is in flight at a
// time; the granted requester receives a single-cycle completion pulse that
// carries the read data and an error flag.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i[NUM_REQ]   request valid, held until the matching rsp_ready_o
//   req_write_i[NUM_REQ]   1 = write, 0 = read
//   req_addr_i/wdata_i/wstrb_i  packed per-requester fields, requester i at slice i
//   rsp_ready_o[NUM_REQ]   one-hot completion pulse
//   rsp_error_o            response was not OKAY (valid with rsp_ready_o)
//   rsp_rdata_o            read data, 0 for writes (valid with rsp_ready_o)
//   aw_* / w_* / b_*       AXI-Lite write address, write data, write response
//   ar_* / r_*             AXI-Lite read address, read data
//   busy_o                 high whenever a transaction is in progress
//   grant_idx_o            index of the current / most recent grant
module axil_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  localparam int STRB_WIDTH    = AXI_DATA_WIDTH / 8,
  localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0]                  req_write_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]       req_wstrb_i,
  output logic [NUM_REQ-1:0]                  rsp_ready_o,
  output logic                                rsp_error_o,
  output logic [AXI_DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic [AXI_ADDR_WIDTH-1:0]           aw_addr_o,
  output logic [2:0]                          aw_prot_o,
  output logic                                aw_valid_o,
  input  logic                                aw_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]           w_data_o,
  output logic [STRB_WIDTH-1:0]               w_strb_o,
  output logic                                w_valid_o,
  input  logic                                w_ready_i,
  input  logic [1:0]                          b_resp_i,
  input  logic                                b_valid_i,
  output logic                                b_ready_o,
  output logic [AXI_ADDR_WIDTH-1:0]           ar_addr_o,
  output logic [2:0]                          ar_prot_o,
  output logic                                ar_valid_o,
  input  logic                                ar_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0]           r_data_i,
  input  logic [1:0]                          r_resp_i,
  input  logic                                r_valid_i,
  output logic                                r_ready_o,
  output logic                                busy_o,
  output logic [IDX_W-1:0]                    grant_idx_o
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WAIT_B       = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_WAIT_R       = 3'd4,
    ST_RESP         = 3'd5
  } state_e;

  // Control state (reset)
  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic                      aw_sent_q, aw_sent_d;
  logic                      w_sent_q, w_sent_d;

  // Transaction data (not reset; only observed through state-gated outputs)
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0]     wstrb_q;
  logic                      err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      load_req;
  logic                      load_rsp;

  // Arbitration results
  logic                      pick_found;
  logic [IDX_W-1:0]          pick_idx;
  logic [IDX_W-1:0]          cand_idx;
  int                        cand;
  logic                      sel_write;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [AXI_DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0]     sel_wstrb;
  logic [IDX_W-1:0]          next_ptr;

  // Internal copies of the state-decoded handshake signals
  logic                      aw_vld;
  logic                      w_vld;
  logic                      ar_vld;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(rr_ptr_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req_valid_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Field mux for the winning requester (constant slice bounds per index).
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        sel_write = req_write_i[i];
        sel_addr  = req_addr_i[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        sel_wdata = req_wdata_i[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        sel_wstrb = req_wstrb_i[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  assign next_ptr = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  // Handshake outputs are pure decodes of registered state.
  assign aw_vld = (state_q == ST_WR_ADDR_DATA) && !aw_sent_q;
  assign w_vld  = (state_q == ST_WR_ADDR_DATA) && !w_sent_q;
  assign ar_vld = (state_q == ST_RD_ADDR);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    aw_sent_d = aw_sent_q;
    w_sent_d  = w_sent_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    load_req  = 1'b0;
    load_rsp  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          load_req  = 1'b1;
          grant_d   = pick_idx;
          rr_ptr_d  = next_ptr;
          aw_sent_d = 1'b0;
          w_sent_d  = 1'b0;
          state_d   = sel_write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
        end
      end

      ST_WR_ADDR_DATA: begin
        // AW and W complete independently, in either order or together.
        aw_sent_d = aw_sent_q | (aw_vld & aw_ready_i);
        w_sent_d  = w_sent_q  | (w_vld  & w_ready_i);
        if (aw_sent_d && w_sent_d) begin
          aw_sent_d = 1'b0;
          w_sent_d  = 1'b0;
          state_d   = ST_WAIT_B;
        end
      end

      ST_WAIT_B: begin
        if (b_valid_i) begin
          load_rsp = 1'b1;
          err_d    = (b_resp_i != 2'b00);
          rdata_d  = '0;
          state_d  = ST_RESP;
        end
      end

      ST_RD_ADDR: begin
        if (ar_ready_i) begin
          state_d = ST_WAIT_R;
        end
      end

      ST_WAIT_R: begin
        if (r_valid_i) begin
          load_rsp = 1'b1;
          err_d    = (r_resp_i != 2'b00);
          rdata_d  = r_data_i;
          state_d  = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        aw_sent_d = 1'b0;
        w_sent_d  = 1'b0;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      aw_sent_q <= aw_sent_d;
      w_sent_q  <= w_sent_d;
    end
  end

  // Transaction data registers
  always_ff @(posedge clk_i) begin
    if (load_req) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      wstrb_q <= sel_wstrb;
    end
    if (load_rsp) begin
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decodes; payloads are forced to 0 whenever their valid is low.
  assign aw_valid_o  = aw_vld;
  assign w_valid_o   = w_vld;
  assign ar_valid_o  = ar_vld;
  assign b_ready_o   = (state_q == ST_WAIT_B);
  assign r_ready_o   = (state_q == ST_WAIT_R);
  assign aw_addr_o   = aw_vld ? addr_q  : '0;
  assign ar_addr_o   = ar_vld ? addr_q  : '0;
  assign w_data_o    = w_vld  ? wdata_q : '0;
  assign w_strb_o    = w_vld  ? wstrb_q : '0;
  assign aw_prot_o   = 3'b000;
  assign ar_prot_o   = 3'b000;
  assign busy_o      = (state_q != ST_IDLE);
  assign grant_idx_o = grant_q;
  assign rsp_error_o = (state_q == ST_RESP) && err_q;
  assign rsp_rdata_o = (state_q == ST_RESP) ? rdata_q : '0;

  always_comb begin
    rsp_ready_o = '0;
    if (state_q == ST_RESP) begin
      rsp_ready_o[grant_q] = 1'b1;
    end
  end

endmodule
